// File: rtl/rc6_pkg.sv
// Shared constants, FSM state type and byte-select helper for the RC6 block
// unpacker (and the future packer).
package rc6_pkg;

  localparam int RC6_BLK_W = 128;
  localparam int RC6_BYTES = 16;

  typedef enum logic {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } rc6_state_e;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] rc6_byte_sel(input logic [RC6_BLK_W-1:0] blk,
                                              input logic [3:0]           idx);
    logic [6:0] base;
    base = {~idx, 3'b000};
    return blk[base +: 8];
  endfunction

endpackage

// File: rtl/rc6_block_unpacker_if.sv
// Block-in / byte-out bus for rc6_block_unpacker.
// RC6_UNPACK_CNT_EN adds the emitted-block and dropped-block counters.
interface rc6_block_unpacker_if;
  import rc6_pkg::*;

  logic [RC6_BLK_W-1:0] i_din;
  logic                 i_din_en;
  logic [7:0]           o_byte;
  logic                 o_byte_en;
  logic                 i_byte_rdy;
  logic                 o_full;
  logic                 o_ovf;
  logic                 o_busy;
`ifdef RC6_UNPACK_CNT_EN
  logic [31:0]          o_blk_cnt;
  logic [15:0]          o_drop_cnt;
`endif

  modport slave (
    input  i_din, i_din_en, i_byte_rdy,
`ifdef RC6_UNPACK_CNT_EN
    output o_blk_cnt, o_drop_cnt,
`endif
    output o_byte, o_byte_en, o_full, o_ovf, o_busy
  );

  modport master (
    output i_din, i_din_en, i_byte_rdy,
`ifdef RC6_UNPACK_CNT_EN
    input  o_blk_cnt, o_drop_cnt,
`endif
    input  o_byte, o_byte_en, o_full, o_ovf, o_busy
  );

endinterface

// File: rtl/rc6_blk_fifo.sv
// DEPTH x DW synchronous block FIFO with combinational head read.
// A pop and push in the same cycle are allowed when full.
module rc6_blk_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 128,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == FULL_CNT);

endmodule

// File: rtl/rc6_block_unpacker.sv
// Serialises 128-bit rc6_core result blocks into an MSB-first byte stream.
// RC6_UNPACK_CNT_EN adds o_blk_cnt (pops) and o_drop_cnt (saturating drops).
//
//   state  | meaning
//   EMPTY  | no block queued, o_byte_en low
//   STREAM | head block being emitted byte by byte
module rc6_block_unpacker
  import rc6_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = RC6_BLK_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rc6_block_unpacker_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  rc6_state_e    state;
  logic [3:0]    idx;
  logic          ovf;
  logic          push;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic [CW-1:0] count;
  logic [DW-1:0] head;

  assign pop  = (state == STREAM) && bus.i_byte_rdy && (idx == 4'hF);
  // A pop frees the slot before the push lands, so a full FIFO still accepts.
  assign push = bus.i_din_en && (!fifo_full || pop);
  assign drop = bus.i_din_en && !push;

  rc6_blk_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .din   (bus.i_din),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (fifo_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= EMPTY;
      idx   <= 4'h0;
      ovf   <= 1'b0;
    end else begin
      if (drop) ovf <= 1'b1;
      case (state)
        EMPTY: begin
          idx <= 4'h0;
          if (push) state <= STREAM;
        end
        STREAM: begin
          if (bus.i_byte_rdy) idx <= idx + 4'h1;
          if (pop && (count == ONE_CNT) && !push) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef RC6_UNPACK_CNT_EN
  logic [31:0] blk_cnt;
  logic [15:0] drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blk_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop) blk_cnt <= blk_cnt + 32'd1;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.o_blk_cnt  = blk_cnt;
  assign bus.o_drop_cnt = drop_cnt;
`endif

  assign bus.o_byte_en = (state == STREAM);
  assign bus.o_busy    = (state == STREAM);
  assign bus.o_byte    = (state == STREAM) ? rc6_byte_sel(head, idx) : 8'h00;
  assign bus.o_full    = fifo_full;
  assign bus.o_ovf     = ovf;

endmodule

// File: tb/tb_rc6_block_unpacker.sv
// Scoreboard bench for rc6_block_unpacker: expected bytes queued on accepted
// pushes, popped by a negedge monitor on every transfer.
module tb_rc6_block_unpacker;
  import rc6_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rc6_block_unpacker_if bus ();

  rc6_block_unpacker #(.DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [7:0]  exp_q[$];
  bit          m_ovf;
  int unsigned m_blk;
  int unsigned m_drop;
  bit          exp_en_now;
  int          vectors;
  int          miscompares;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check flags against the model, then apply this cycle's inputs.
  task automatic drive(input bit r, input bit en, input logic [127:0] d, input bit rdy);
    int  len;
    int  blocks;
    bit  pop_now;
    @(posedge clk);
    #1;
    len    = exp_q.size();
    blocks = (len + 15) / 16;
    if (!rst) begin
      chk("full",    32'(bus.o_full),    32'(blocks == DEPTH));
      chk("busy",    32'(bus.o_busy),    32'(len > 0));
      chk("byte_en", 32'(bus.o_byte_en), 32'(len > 0));
      chk("ovf",     32'(bus.o_ovf),     32'(m_ovf));
      if (len == 0) chk("idle_byte", 32'(bus.o_byte), 32'h0);
`ifdef RC6_UNPACK_CNT_EN
      chk("blk_cnt",  bus.o_blk_cnt,        m_blk);
      chk("drop_cnt", 32'(bus.o_drop_cnt),  (m_drop > 16'hFFFF) ? 32'hFFFF : m_drop);
`endif
    end
    rst            = r;
    bus.i_din_en   = en;
    bus.i_din      = d;
    bus.i_byte_rdy = rdy;
    exp_en_now     = (len > 0);
    if (r) begin
      exp_q.delete();
      m_ovf  = 0;
      m_blk  = 0;
      m_drop = 0;
    end else if (en) begin
      pop_now = rdy && (len > 0) && (len % 16 == 1);
      if (blocks < DEPTH || pop_now) begin
        for (int b = 0; b < 16; b++) exp_q.push_back(d[127 - 8*b -: 8]);
      end else begin
        m_ovf = 1;
        m_drop++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("en_timing", 32'(bus.o_byte_en), 32'(exp_en_now));
      if (bus.o_byte_en && bus.i_byte_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(bus.o_byte_en), 32'h0);
        end else begin
          chk("byte", 32'(bus.o_byte), 32'(exp_q.pop_front()));
          if (exp_q.size() % 16 == 0) m_blk++;
        end
      end
    end
  end

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, '0, rdy);
  endtask

  initial begin
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    int budget;
    bus.i_din      = '0;
    bus.i_din_en   = 1'b0;
    bus.i_byte_rdy = 1'b0;
    drive(1, 0, '0, 0);
    drive(1, 0, '0, 0);
    drive(0, 0, '0, 1);
    idle(2, 1);

    // single block, counting pattern
    drive(0, 1, 128'h000102030405060708090A0B0C0D0E0F, 1);
    idle(20, 1);

    // back-pressure 1,0,0,1,...
    drive(0, 1, rand_blk(), 0);
    for (int i = 0; i < 48; i++) drive(0, 0, '0, (i % 3) == 0);
    idle(5, 1);

    // back-to-back A then B three cycles later
    blk_a = {16{8'hAA}};
    blk_b = {16{8'h55}};
    drive(0, 1, blk_a, 1);
    idle(2, 1);
    drive(0, 1, blk_b, 1);
    idle(35, 1);

    // overflow: third push dropped while stalled
    drive(0, 1, rand_blk(), 0);
    drive(0, 1, rand_blk(), 0);
    drive(0, 1, rand_blk(), 0);
    idle(3, 0);
    idle(36, 1);

    // reset clears sticky ovf; then full with coincident byte-15 pop
    drive(1, 0, '0, 0);
    drive(0, 1, rand_blk(), 0);
    drive(0, 1, rand_blk(), 0);
    idle(15, 1);
    drive(0, 1, rand_blk(), 1);
    idle(36, 1);

    // reset mid-stream after byte 5, then restart
    drive(0, 1, rand_blk(), 1);
    idle(6, 1);
    drive(1, 0, '0, 0);
    idle(2, 1);
    drive(0, 1, 128'h00112233445566778899AABBCCDDEEFF, 1);
    idle(20, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      drive(0, $urandom_range(0, 5) == 0, rand_blk(), $urandom_range(0, 3) != 0);

    budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      drive(0, 0, '0, 1);
      budget--;
    end
    chk("drain_left", 32'(exp_q.size()), 32'h0);
    idle(2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
